// File: rtl/hmmm_loader_if.sv
// Byte-stream input and core program-load pins of the hmmm loader.
// master: upstream source / core side; slave: the loader.
interface hmmm_loader_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] io_out;
  logic              io_oe;
  logic              pgrm_addr;
  logic              pgrm_data;
  logic              core_rst;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, io_out, io_oe, pgrm_addr, pgrm_data, core_rst
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, io_out, io_oe, pgrm_addr, pgrm_data, core_rst
  );
endinterface

// File: rtl/hmmm_loader.sv
// Program loader for the hmmm core: bytes -> 16-bit words -> core RAM, then a core reset pulse.
// Define HMMM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module hmmm_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  hmmm_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [ADDR_W-1:0] StartAddr = START_ADDR[ADDR_W-1:0];
  localparam logic [7:0]        RstLast   = 8'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StHi, StLo, StAddr, StData, StChk, StReset, StDone, StError
  } state_e;

  state_e              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          rst_cnt_q, rst_cnt_d;
  logic                xfer;
`ifdef HMMM_LOADER_CHECKSUM_EN
  logic [7:0]          xsum_q, xsum_d;
`endif

  assign xfer = bus.rx_valid & bus.rx_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    word_d    = word_q;
    rst_cnt_d = rst_cnt_q;
`ifdef HMMM_LOADER_CHECKSUM_EN
    xsum_d    = xsum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (xfer) begin
          // A count byte of zero stands for 256 words.
          cnt_d   = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
          addr_d  = StartAddr;
          state_d = StHi;
`ifdef HMMM_LOADER_CHECKSUM_EN
          xsum_d  = 8'd0;
`endif
        end
      end
      StHi: begin
        if (xfer) begin
          word_d[15:8] = bus.rx_data;
          state_d      = StLo;
`ifdef HMMM_LOADER_CHECKSUM_EN
          xsum_d       = xsum_q ^ bus.rx_data;
`endif
        end
      end
      StLo: begin
        if (xfer) begin
          word_d[7:0] = bus.rx_data;
          state_d     = StAddr;
`ifdef HMMM_LOADER_CHECKSUM_EN
          xsum_d      = xsum_q ^ bus.rx_data;
`endif
        end
      end
      StAddr: state_d = StData;
      StData: begin
        addr_d    = addr_q + 1'b1;
        cnt_d     = cnt_q - 9'd1;
        rst_cnt_d = 8'd0;
        if (cnt_q == 9'd1) begin
`ifdef HMMM_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StReset;
`endif
        end else begin
          state_d = StHi;
        end
      end
`ifdef HMMM_LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          state_d = (bus.rx_data == xsum_q) ? StReset : StError;
        end
      end
`endif
      StReset: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StDone;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      word_q        <= '0;
      rst_cnt_q     <= '0;
      bus.rx_ready  <= 1'b0;
      bus.io_out    <= '0;
      bus.io_oe     <= 1'b0;
      bus.pgrm_addr <= 1'b0;
      bus.pgrm_data <= 1'b0;
      bus.core_rst  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      word_q        <= word_d;
      rst_cnt_q     <= rst_cnt_d;
      bus.rx_ready  <= state_d inside {StIdle, StHi, StLo, StChk, StDone, StError};
      bus.io_oe     <= state_d inside {StAddr, StData};
      bus.pgrm_addr <= (state_d == StAddr);
      bus.pgrm_data <= (state_d == StData);
      bus.core_rst  <= (state_d == StReset);
      busy          <= !(state_d inside {StIdle, StDone, StError});
      done          <= (state_d == StDone);
      if (state_d == StAddr) begin
        bus.io_out <= {{(DATA_W-ADDR_W){1'b0}}, addr_d};
      end else if (state_d == StData) begin
        bus.io_out <= word_d;
      end else begin
        bus.io_out <= '0;
      end
    end
  end

`ifdef HMMM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xsum_q <= '0;
      err    <= 1'b0;
    end else begin
      xsum_q <= xsum_d;
      err    <= (state_d == StError);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
